// File: rtl/k_fifo_rptr_empty_t1.sv
// Read-side pointer and empty-flag logic for an asynchronous FIFO.
// Synchronizes the write Gray pointer into the read clock domain, advances
// the read Gray pointer on accepted reads, and produces registered empty,
// almost-empty and fill-level outputs. Flags are computed from the
// synchronized write pointer, so they can only err towards "more empty".
module k_fifo_rptr_empty_t1 #(
  parameter int DATA_SIZE = 4,
  parameter int AE_LEVEL  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [DATA_SIZE-1:0] wgray_async,
  output logic [DATA_SIZE-1:0] rgray,
  output logic [DATA_SIZE-2:0] raddr,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [DATA_SIZE-1:0] rlevel
);

  localparam logic [DATA_SIZE-1:0] AE_THRESH = DATA_SIZE'(AE_LEVEL);

  logic [DATA_SIZE-1:0] wq1;
  logic [DATA_SIZE-1:0] wq2;
  logic [DATA_SIZE-1:0] rbin;
  logic [DATA_SIZE-1:0] bin_next;
  logic [DATA_SIZE-1:0] rgray_next;
  logic [DATA_SIZE-1:0] wbin;
  logic [DATA_SIZE-1:0] level_next;
  logic                 rd_accept;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [DATA_SIZE-1:0] gray2bin(input logic [DATA_SIZE-1:0] g);
    logic [DATA_SIZE-1:0] b;
    b[DATA_SIZE-1] = g[DATA_SIZE-1];
    for (int i = DATA_SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Two-flop synchronizer for the write pointer; nothing sits between stages.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so wq2 samples the
    // old wq1 rather than the value written earlier in this same edge.
    if (rst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wgray_async;
      wq2 <= wq1;
    end
  end

  // Next read pointer and next flag values, all derived from registered state.
  always_comb begin
    // NOTE: every output of this block is assigned on every path so no latch
    // is inferred; the reads of rempty gate the pointer increment.
    rd_accept  = rd_en & ~rempty;
    rbin       = gray2bin(rgray);
    bin_next   = rbin + {{(DATA_SIZE-1){1'b0}}, rd_accept};
    rgray_next = bin_next ^ (bin_next >> 1);
    wbin       = gray2bin(wq2);
    level_next = wbin - bin_next;
  end

  // Read pointer and flag registers; reset wins over any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgray         <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rgray         <= rgray_next;
      rempty        <= (rgray_next == wq2);
      ralmost_empty <= (level_next <= AE_THRESH);
      rlevel        <= level_next;
    end
  end

  // Dual-Gray RAM address: fold the top two Gray bits so the address stays a
  // Gray sequence over the half-size address space without an extra register.
  assign raddr = {rgray[DATA_SIZE-1] ^ rgray[DATA_SIZE-2], rgray[DATA_SIZE-3:0]};

endmodule

// File: tb/tb_k_fifo_rptr_empty_t1.sv
// Self-checking bench for k_fifo_rptr_empty_t1 (DATA_SIZE=4, AE_LEVEL=1).
// The reference model tracks total writes and total accepted reads as plain
// integers, delays the write count by two edges, and derives level/flags and
// pointer encodings arithmetically.
module tb_k_fifo_rptr_empty_t1;

  localparam int DS = 4;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic [DS-1:0] wgray_async = '0;
  logic [DS-1:0] rgray;
  logic [DS-2:0] raddr;
  logic          rempty;
  logic          ralmost_empty;
  logic [DS-1:0] rlevel;

  k_fifo_rptr_empty_t1 #(.DATA_SIZE(DS), .AE_LEVEL(AE)) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wgray_async(wgray_async),
    .rgray(rgray),
    .raddr(raddr),
    .rempty(rempty),
    .ralmost_empty(ralmost_empty),
    .rlevel(rlevel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            wbin      = 0;  // total entries written (driven)
  int            acc_count = 0;  // total reads accepted since reset
  int            m_w1      = 0;  // write count seen one edge ago
  int            m_w2      = 0;  // write count visible to the flags
  logic [DS-1:0] exp_rgray = '0;
  logic [DS-2:0] exp_raddr = '0;
  logic          exp_rempty = 1'b1;
  logic          exp_ralmost = 1'b1;
  logic [DS-1:0] exp_rlevel = '0;

  function automatic logic [DS-1:0] gray4(input int b);
    int v;
    v = b % 16;
    return 4'(v ^ (v >> 1));
  endfunction

  function automatic logic [DS-2:0] gray3(input int b);
    int v;
    v = b % 8;
    return 3'(v ^ (v >> 1));
  endfunction

  task automatic set_w(input int n);
    wbin        = n;
    wgray_async = gray4(n);
  endtask

  // Advance one clock edge and update the model from the inputs at that edge.
  task automatic step();
    int lvl;
    @(posedge clk);
    if (rst) begin
      acc_count   = 0;
      m_w1        = 0;
      m_w2        = 0;
      exp_rempty  = 1'b1;
      exp_ralmost = 1'b1;
      exp_rlevel  = '0;
    end else begin
      if (rd_en && !exp_rempty) acc_count++;
      lvl         = (((m_w2 - acc_count) % 16) + 16) % 16;
      exp_rlevel  = 4'(lvl);
      exp_rempty  = (lvl == 0);
      exp_ralmost = (lvl <= AE);
      m_w2        = m_w1;
      m_w1        = wbin % 16;
    end
    exp_rgray = gray4(acc_count);
    exp_raddr = gray3(acc_count);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; set_w(0);
    step(); step();
    n_tests++; if (rgray !== 4'b0000) begin n_fail++; $display("FAIL reset_rgray got=%b exp=0000", rgray); end
    n_tests++; if (raddr !== 3'b000) begin n_fail++; $display("FAIL reset_raddr got=%b exp=000", raddr); end
    n_tests++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty got=%b exp=1", rempty); end
    n_tests++; if (ralmost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ralmost got=%b exp=1", ralmost_empty); end
    n_tests++; if (rlevel !== 4'd0) begin n_fail++; $display("FAIL reset_rlevel got=%0d exp=0", rlevel); end
    rst = 1'b0;
  endtask

  task automatic test_sync_latency();
    set_w(1);
    step();
    n_tests++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL sync_e1_rempty got=%b exp=1", rempty); end
    step();
    n_tests++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL sync_e2_rempty got=%b exp=1", rempty); end
    step();
    n_tests++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL sync_e3_rempty got=%b exp=0", rempty); end
    n_tests++; if (rlevel !== 4'd1) begin n_fail++; $display("FAIL sync_e3_rlevel got=%0d exp=1", rlevel); end
    n_tests++; if (ralmost_empty !== 1'b1) begin n_fail++; $display("FAIL sync_e3_ralmost got=%b exp=1", ralmost_empty); end
  endtask

  task automatic test_empty_read();
    rst = 1'b1; set_w(0); step(); rst = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (rgray !== 4'b0000) begin n_fail++; $display("FAIL empty_read_rgray cyc=%0d got=%b exp=0000", i, rgray); end
      n_tests++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL empty_read_rempty cyc=%0d got=%b exp=1", i, rempty); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_drain();
    logic [2:0] seq [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    int wait_cnt = 0;
    set_w(4);
    while (rempty && wait_cnt < 10) begin step(); wait_cnt++; end
    n_tests++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL drain_wait_timeout got_rempty=%b exp=0", rempty); end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (raddr !== seq[i]) begin n_fail++; $display("FAIL drain_raddr idx=%0d got=%b exp=%b", i, raddr, seq[i]); end
      step();
    end
    n_tests++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL drain_end_rempty got=%b exp=1", rempty); end
    n_tests++; if (rgray !== 4'b0110) begin n_fail++; $display("FAIL drain_end_rgray got=%b exp=0110", rgray); end
    n_tests++; if (rlevel !== 4'd0) begin n_fail++; $display("FAIL drain_end_rlevel got=%0d exp=0", rlevel); end
    step();
    n_tests++; if (rgray !== 4'b0110) begin n_fail++; $display("FAIL drain_5th_rgray got=%b exp=0110", rgray); end
    n_tests++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL drain_5th_rempty got=%b exp=1", rempty); end
    rd_en = 1'b0;
  endtask

  task automatic test_wrap();
    bit seen_4 = 0, seen_c = 0, seen_8 = 0, seen_0 = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (wbin < 20 && (wbin - acc_count) < 8) set_w(wbin + 1);
      step();
      n_tests++; if (rgray !== exp_rgray) begin n_fail++; $display("FAIL wrap_rgray cyc=%0d got=%b exp=%b", i, rgray, exp_rgray); end
      n_tests++; if (raddr !== exp_raddr) begin n_fail++; $display("FAIL wrap_raddr cyc=%0d got=%b exp=%b", i, raddr, exp_raddr); end
      n_tests++; if (rempty !== exp_rempty) begin n_fail++; $display("FAIL wrap_rempty cyc=%0d got=%b exp=%b", i, rempty, exp_rempty); end
      n_tests++; if (rlevel !== exp_rlevel) begin n_fail++; $display("FAIL wrap_rlevel cyc=%0d got=%0d exp=%0d", i, rlevel, exp_rlevel); end
      if (rgray === 4'b0100 && raddr === 3'b100) seen_4 = 1;
      if (rgray === 4'b1100 && raddr === 3'b000) seen_c = 1;
      if (rgray === 4'b1000) seen_8 = 1;
      if (seen_8 && rgray === 4'b0000) seen_0 = 1;
      if (acc_count == 20 && rempty) break;
    end
    n_tests++; if (!seen_4) begin n_fail++; $display("FAIL wrap_seen_0100 got=0 exp=1"); end
    n_tests++; if (!seen_c) begin n_fail++; $display("FAIL wrap_seen_1100 got=0 exp=1"); end
    n_tests++; if (!seen_8) begin n_fail++; $display("FAIL wrap_seen_1000 got=0 exp=1"); end
    n_tests++; if (!seen_0) begin n_fail++; $display("FAIL wrap_seen_0000 got=0 exp=1"); end
    n_tests++; if (rgray !== 4'b0110) begin n_fail++; $display("FAIL wrap_end_rgray got=%b exp=0110", rgray); end
    rd_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    int wait_cnt = 0;
    rst = 1'b1; set_w(0); step(); rst = 1'b0;
    set_w(3);
    while (rlevel !== 4'd3 && wait_cnt < 10) begin step(); wait_cnt++; end
    n_tests++; if (rlevel !== 4'd3) begin n_fail++; $display("FAIL midrst_setup_rlevel got=%0d exp=3", rlevel); end
    rd_en = 1'b1; rst = 1'b1;
    step();
    n_tests++; if (rgray !== 4'b0000) begin n_fail++; $display("FAIL midrst_rgray got=%b exp=0000", rgray); end
    n_tests++; if (raddr !== 3'b000) begin n_fail++; $display("FAIL midrst_raddr got=%b exp=000", raddr); end
    n_tests++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL midrst_rempty got=%b exp=1", rempty); end
    n_tests++; if (ralmost_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_ralmost got=%b exp=1", ralmost_empty); end
    n_tests++; if (rlevel !== 4'd0) begin n_fail++; $display("FAIL midrst_rlevel got=%0d exp=0", rlevel); end
    rst = 1'b0; rd_en = 1'b0;
    wait_cnt = 0;
    while (rempty && wait_cnt < 10) begin step(); wait_cnt++; end
    n_tests++; if (rlevel !== 4'd3) begin n_fail++; $display("FAIL midrst_resume_rlevel got=%0d exp=3", rlevel); end
    rd_en = 1'b1;
    step();
    n_tests++; if (rgray !== 4'b0001) begin n_fail++; $display("FAIL midrst_resume_rgray got=%b exp=0001", rgray); end
    rd_en = 1'b0;
  endtask

  task automatic test_random();
    rst = 1'b1; set_w(0); step(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      if ((wbin - acc_count) < 8 && $urandom_range(0, 2) != 0) set_w(wbin + 1);
      step();
      n_tests++; if (rgray !== exp_rgray) begin n_fail++; $display("FAIL rand_rgray cyc=%0d got=%b exp=%b", i, rgray, exp_rgray); end
      n_tests++; if (raddr !== exp_raddr) begin n_fail++; $display("FAIL rand_raddr cyc=%0d got=%b exp=%b", i, raddr, exp_raddr); end
      n_tests++; if (rempty !== exp_rempty) begin n_fail++; $display("FAIL rand_rempty cyc=%0d got=%b exp=%b", i, rempty, exp_rempty); end
      n_tests++; if (ralmost_empty !== exp_ralmost) begin n_fail++; $display("FAIL rand_ralmost cyc=%0d got=%b exp=%b", i, ralmost_empty, exp_ralmost); end
      n_tests++; if (rlevel !== exp_rlevel) begin n_fail++; $display("FAIL rand_rlevel cyc=%0d got=%0d exp=%0d", i, rlevel, exp_rlevel); end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_empty_read();
    test_drain();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
